// File: rtl/seq_multiplier_if.sv
// Handshake/operand bundle between a requester and the sequential multiplier.
// Latency: none (wires only).
// Backpressure: START is honoured only while the multiplier is idle; BUSY/DONE report progress.
interface seq_multiplier_if #(
    parameter int C_NUM_BITS = 24
);
    logic                      E;
    logic                      START;
    logic [C_NUM_BITS-1:0]     A;
    logic [C_NUM_BITS-1:0]     B;
    logic [2*C_NUM_BITS-1:0]   P;
    logic                      BUSY;
    logic                      DONE;

    // Requester side: drives enable, start and operands; observes result and status.
    modport master (
        output E, START, A, B,
        input  P, BUSY, DONE
    );

    // Multiplier side.
    modport slave (
        input  E, START, A, B,
        output P, BUSY, DONE
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier, one partial-product bit per enabled clock.
// Latency: DONE pulses after C_NUM_BITS enabled edges following START acceptance.
// Backpressure: START ignored (not queued) while BUSY or DONE; E=0 freezes everything.
module seq_multiplier #(
    parameter int C_NUM_BITS = 24
) (
    input  logic               CK,
    input  logic               RN,
    seq_multiplier_if.slave    bus
);

    localparam int CW = $clog2(C_NUM_BITS + 1);
    localparam int PW = 2 * C_NUM_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    // Multiplicand held for the whole operation; multiplier shifts right and
    // its vacated MSBs collect the low half of the product as it forms.
    logic [C_NUM_BITS-1:0]   mcand;
    logic [C_NUM_BITS-1:0]   mplier;
    logic [C_NUM_BITS:0]     acc_hi;
    logic [CW-1:0]           cnt;
    logic [PW-1:0]           p_q;

    logic [C_NUM_BITS:0]     sum;
    logic [C_NUM_BITS:0]     acc_nxt;
    logic [C_NUM_BITS-1:0]   mplier_nxt;
    logic                    last_iter;

    // One shift-add step: conditionally add the multiplicand, then shift the
    // {acc_hi, mplier} pair right by one with zero fill.
    always_comb begin
        sum        = acc_hi + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt    = {1'b0, sum[C_NUM_BITS:1]};
        mplier_nxt = {sum[0], mplier[C_NUM_BITS-1:1]};
    end

    // The counter runs 0..C_NUM_BITS-1 across the iterations; the last value
    // marks the edge that completes the product.
    assign last_iter = (cnt == CW'(C_NUM_BITS - 1));

    // State register; E=0 holds the current state.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else if (bus.E) begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE_ST;
            DONE_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and product register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            cnt    <= '0;
            p_q    <= '0;
        end else if (bus.E) begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        mcand  <= bus.A;
                        mplier <= bus.B;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CW'(1);
                    // P only changes here, so it holds the previous result
                    // through idle time and the whole next operation.
                    if (last_iter) begin
                        p_q <= {acc_nxt[C_NUM_BITS-1:0], mplier_nxt};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status is decoded from state only, so there is no input-to-output path.
    assign bus.BUSY = (state == RUN);
    assign bus.DONE = (state == DONE_ST);
    assign bus.P    = p_q;

endmodule
